// File: rtl/municao_pkg.sv
// ============================================================================
// Module      : municao_pkg
// Description : Shared state encodings and default geometry for the shot
//               controller and the ammunition renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package municao_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLIGHT   = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_e;

   // The renderer uses the same launch height so the shot leaves the drawn bar.
   localparam int DEF_LAUNCH_Y    = 489;
   localparam int DEF_TOP_Y       = 2;
   localparam int DEF_STEP        = 4;
   localparam int DEF_MAX_AMMO    = 8;
   localparam int DEF_COOLDOWN_FR = 6;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/municao_frame_timer.sv
// ============================================================================
// Module      : municao_frame_timer
// Description : Frame-tick driven down-counter; done pulses with the tick that
//               exhausts the loaded count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module municao_frame_timer
   import municao_pkg::*;
#(
   parameter int LOAD_VAL = DEF_COOLDOWN_FR
)(
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic tick_i,
   output logic done_o
);

   localparam int               CNT_W  = cnt_width(LOAD_VAL);
   localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(LOAD_VAL);
   localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A zero load still waits for one tick so the caller always sees a done.
   always_comb begin
      cnt_d  = cnt_q;
      done_o = 1'b0;
      if (load_i) begin
         cnt_d = c_LOAD;
      end else if (tick_i) begin
         done_o = (cnt_q <= c_ONE);
         cnt_d  = (cnt_q == '0) ? '0 : cnt_q - c_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/municao_ctrl.sv
// ============================================================================
// Module      : municao_ctrl
// Description : Shot controller - launches one projectile from the bar, steps
//               it upward each frame, retires it and tracks the ammo count.
//               Optional build macro: MUNICAO_AUTOFIRE_EN (level-triggered fire).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module municao_ctrl
   import municao_pkg::*;
#(
   parameter int X_W         = 11,
   parameter int Y_W         = 10,
   parameter int LAUNCH_Y    = DEF_LAUNCH_Y,
   parameter int TOP_Y       = DEF_TOP_Y,
   parameter int STEP        = DEF_STEP,
   parameter int MAX_AMMO    = DEF_MAX_AMMO,
   parameter int COOLDOWN_FR = DEF_COOLDOWN_FR
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             frame_tick,
   input  logic                             fire,
   input  logic [X_W-1:0]                   bar_x,
   input  logic                             hit,
   input  logic                             reload,
   output logic [X_W-1:0]                   shot_x,
   output logic [Y_W-1:0]                   shot_y,
   output logic                             shot_active,
   output logic                             fire_ack,
   output logic [$clog2(MAX_AMMO+1)-1:0]    ammo_count
);

   localparam int             CW           = $clog2(MAX_AMMO + 1);
   localparam logic [Y_W-1:0] c_LAUNCH_Y   = Y_W'(LAUNCH_Y);
   localparam logic [Y_W-1:0] c_STEP       = Y_W'(STEP);
   localparam logic [Y_W-1:0] c_RETIRE_Y   = Y_W'(TOP_Y + STEP);
   localparam logic [CW-1:0]  c_MAX_AMMO   = CW'(MAX_AMMO);
   localparam logic [CW-1:0]  c_ONE        = CW'(1);

   state_e         state_q, state_d;
   logic [X_W-1:0] shot_x_q, shot_x_d;
   logic [Y_W-1:0] shot_y_q, shot_y_d;
   logic           active_q, active_d;
   logic           ack_q, ack_d;
   logic [CW-1:0]  ammo_q, ammo_d;
   logic           fire_q;

   logic           w_launch_req;
   logic           w_retire;
   logic           w_cool_done;

`ifdef MUNICAO_AUTOFIRE_EN
   assign w_launch_req = fire;
`else
   assign w_launch_req = fire & ~fire_q;
`endif

   municao_frame_timer #(
      .LOAD_VAL (COOLDOWN_FR)
   ) u_cooldown (
      .clk    (clk),
      .reset  (reset),
      .load_i (w_retire),
      .tick_i (frame_tick),
      .done_o (w_cool_done)
   );

   always_comb begin
      state_d  = state_q;
      shot_x_d = shot_x_q;
      shot_y_d = shot_y_q;
      active_d = active_q;
      ack_d    = 1'b0;
      ammo_d   = reload ? c_MAX_AMMO : ammo_q;
      w_retire = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Eligibility looks at the registered count; a same-cycle reload
            // only changes the value that gets decremented.
            if (w_launch_req && (ammo_q != '0)) begin
               state_d  = ST_FLIGHT;
               shot_x_d = bar_x;
               shot_y_d = c_LAUNCH_Y;
               active_d = 1'b1;
               ack_d    = 1'b1;
               ammo_d   = ammo_d - c_ONE;
            end
         end
         ST_FLIGHT: begin
            if (hit) begin
               w_retire = 1'b1;
            end else if (frame_tick) begin
               if (shot_y_q < c_RETIRE_Y) begin
                  w_retire = 1'b1;
               end else begin
                  shot_y_d = shot_y_q - c_STEP;
               end
            end
         end
         ST_COOLDOWN: begin
            if (w_cool_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (w_retire) begin
         active_d = 1'b0;
         state_d  = ST_COOLDOWN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         shot_x_q <= '0;
         shot_y_q <= c_LAUNCH_Y;
         active_q <= 1'b0;
         ack_q    <= 1'b0;
         ammo_q   <= c_MAX_AMMO;
         fire_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shot_x_q <= shot_x_d;
         shot_y_q <= shot_y_d;
         active_q <= active_d;
         ack_q    <= ack_d;
         ammo_q   <= ammo_d;
         fire_q   <= fire;
      end
   end

   assign shot_x      = shot_x_q;
   assign shot_y      = shot_y_q;
   assign shot_active = active_q;
   assign fire_ack    = ack_q;
   assign ammo_count  = ammo_q;

endmodule

`default_nettype wire

// File: tb/tb_municao_ctrl.sv
// ============================================================================
// Module      : tb_municao_ctrl
// Description : Scoreboard bench for municao_ctrl - directed scenarios followed
//               by random traffic against a frame-level behavioural model.
//               Honours MUNICAO_AUTOFIRE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_municao_ctrl;

   localparam int X_W         = 11;
   localparam int Y_W         = 10;
   localparam int LAUNCH_Y    = 489;
   localparam int TOP_Y       = 2;
   localparam int STEP        = 4;
   localparam int MAX_AMMO    = 8;
   localparam int COOLDOWN_FR = 6;
   localparam int CW          = $clog2(MAX_AMMO + 1);

   logic           clk = 1'b0;
   logic           reset;
   logic           frame_tick;
   logic           fire;
   logic [X_W-1:0] bar_x;
   logic           hit;
   logic           reload;
   logic [X_W-1:0] shot_x;
   logic [Y_W-1:0] shot_y;
   logic           shot_active;
   logic           fire_ack;
   logic [CW-1:0]  ammo_count;

   always #5 clk = ~clk;

   municao_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .fire        (fire),
      .bar_x       (bar_x),
      .hit         (hit),
      .reload      (reload),
      .shot_x      (shot_x),
      .shot_y      (shot_y),
      .shot_active (shot_active),
      .fire_ack    (fire_ack),
      .ammo_count  (ammo_count)
   );

   typedef struct {
      int x;
      int y;
      int act;
      int ack;
      int ammo;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // Model: a shot is either flying, cooling down for N more frames, or absent.
   int m_x, m_y, m_ammo, m_cool, m_act, m_ack, m_pfire;

   function void model_step();
      int  launch;
      int  next_ammo;
      if (reset) begin
         m_x = 0; m_y = LAUNCH_Y; m_act = 0; m_ack = 0;
         m_ammo = MAX_AMMO; m_cool = 0; m_pfire = 0;
         return;
      end
`ifdef MUNICAO_AUTOFIRE_EN
      launch = int'(fire);
`else
      launch = (fire && !m_pfire) ? 1 : 0;
`endif
      next_ammo = reload ? MAX_AMMO : m_ammo;
      m_ack = 0;
      if (m_act != 0) begin
         if (hit) begin
            m_act = 0; m_cool = COOLDOWN_FR;
         end else if (frame_tick) begin
            if (m_y < TOP_Y + STEP) begin
               m_act = 0; m_cool = COOLDOWN_FR;
            end else begin
               m_y = m_y - STEP;
            end
         end
      end else if (m_cool > 0) begin
         if (frame_tick) m_cool = m_cool - 1;
      end else if (launch != 0 && m_ammo != 0) begin
         m_x = int'(bar_x); m_y = LAUNCH_Y; m_act = 1; m_ack = 1;
         next_ammo = next_ammo - 1;
      end
      m_ammo  = next_ammo;
      m_pfire = int'(fire);
   endfunction

   task automatic step();
      exp_t e;
      model_step();
      e.x = m_x; e.y = m_y; e.act = m_act; e.ack = m_ack; e.ammo = m_ammo;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
      end
   endtask

   task automatic press();
      fire = 1'b1; step();
      fire = 1'b0; step();
   endtask

   task automatic chk(input string nm, input int got, input int want);
      if (got != want) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_vec++;
         chk("shot_x",      int'(shot_x),      e.x);
         chk("shot_y",      int'(shot_y),      e.y);
         chk("shot_active", int'(shot_active), e.act);
         chk("fire_ack",    int'(fire_ack),    e.ack);
         chk("ammo_count",  int'(ammo_count),  e.ammo);
      end
   end

   initial begin
      reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; bar_x = '0;
      hit = 1'b0; reload = 1'b0;
      @(negedge clk);
      step(); step();
      reset = 1'b0;

      // Launch from bar 300, fly three frames, then move the bar.
      bar_x = 11'd300;
      press();
      tick(3);
      bar_x = 11'd500;
      step();

      // Fly to the top edge, press during cooldown, let cooldown expire.
      tick(120);
      press();
      tick(COOLDOWN_FR);
      step();

      // Hit coincident with a frame tick.
      press();
      tick(22);
      hit = 1'b1; frame_tick = 1'b1; step();
      hit = 1'b0; frame_tick = 1'b0; step();
      tick(COOLDOWN_FR);

      // Exhaust the magazine, then reload alone and reload during a launch.
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < MAX_AMMO + 1; i++) begin
         press();
         hit = 1'b1; step(); hit = 1'b0;
         tick(COOLDOWN_FR);
      end
      reload = 1'b1; step(); reload = 1'b0; step();
      fire = 1'b1; reload = 1'b1; step();
      fire = 1'b0; reload = 1'b0; step();

      // Reset mid-flight.
      tick(4);
      reset = 1'b1; step(); reset = 1'b0; step();

`ifdef MUNICAO_AUTOFIRE_EN
      // Held button re-fires as soon as cooldown finishes.
      fire = 1'b1; step();
      hit = 1'b1; step(); hit = 1'b0;
      tick(COOLDOWN_FR);
      step(); step();
      fire = 1'b0; step();
      hit = 1'b1; step(); hit = 1'b0;
      tick(COOLDOWN_FR);
`endif

      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(7, 0) == 0) fire = ~fire;
         bar_x      = X_W'($urandom_range(2047, 0));
         frame_tick = ($urandom_range(2, 0) == 0);
         hit        = ($urandom_range(149, 0) == 0);
         reload     = ($urandom_range(399, 0) == 0);
         reset      = ($urandom_range(2999, 0) == 0);
         step();
      end
      reset = 1'b0; fire = 1'b0; frame_tick = 1'b0; hit = 1'b0; reload = 1'b0;
      step(); step();

      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
